// File: rtl/exe_unit_w47_core_if.sv
// ---------------------------------------------------------------------------
// exe_unit_w47_core_if
// Operand/opcode/result bundle for the w47 execution unit.
//
// Signals:
//   i_argA   [MBIT-1:0]  operand A (two's complement where signed)
//   i_argB   [MBIT-1:0]  operand B (two's complement where signed; unsigned
//                        shift amount for SHR)
//   i_oper   [NBIT-1:0]  opcode
//   o_result [MBIT-1:0]  registered result returned by the unit
//
// Modports:
//   master : decode side, drives operands/opcode and observes the result
//   slave  : execution unit, consumes operands/opcode and drives the result
// ---------------------------------------------------------------------------
interface exe_unit_w47_core_if #(
  parameter int MBIT = 4,
  parameter int NBIT = 2
);

  logic [MBIT-1:0] i_argA;
  logic [MBIT-1:0] i_argB;
  logic [NBIT-1:0] i_oper;
  logic [MBIT-1:0] o_result;

  modport master (
    output i_argA,
    output i_argB,
    output i_oper,
    input  o_result
  );

  modport slave (
    input  i_argA,
    input  i_argB,
    input  i_oper,
    output o_result
  );

endinterface : exe_unit_w47_core_if

// File: rtl/exe_unit_w47_core.sv
// ---------------------------------------------------------------------------
// exe_unit_w47_core
// Single-stage ALU slice for the w47 datapath. Each rising edge registers one
// of four results computed from the operands presented on the bus:
//   op 0 SUB    : A - B, modulo 2^MBIT
//   op 1 SGT    : 1 if signed(A) > signed(B), else 0
//   op 2 SHR    : A >> unsigned(B), zero fill; 0 when B >= MBIT
//   op 3 POPCNT : number of set bits in A (B ignored)
//   other codes : 0
//
// Ports:
//   i_clk  : clock, all state changes on the rising edge
//   i_rsn  : asynchronous active-high reset, clears the result register
//   bus    : slave side of exe_unit_w47_core_if (operands in, result out)
// ---------------------------------------------------------------------------
module exe_unit_w47_core #(
  parameter int MBIT = 4,
  parameter int NBIT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rsn,
  exe_unit_w47_core_if.slave   bus
);

  localparam logic [NBIT-1:0] OP_SUB    = NBIT'(0);
  localparam logic [NBIT-1:0] OP_SGT    = NBIT'(1);
  localparam logic [NBIT-1:0] OP_SHR    = NBIT'(2);
  localparam logic [NBIT-1:0] OP_POPCNT = NBIT'(3);

  logic [MBIT-1:0] arg_a;
  logic [MBIT-1:0] arg_b;
  logic [NBIT-1:0] oper;

  assign arg_a = bus.i_argA;
  assign arg_b = bus.i_argB;
  assign oper  = bus.i_oper;

  // -------------------------------------------------------------------------
  // Per-operation datapaths, all evaluated in parallel and selected below.
  // -------------------------------------------------------------------------
  logic [MBIT-1:0] sub_res;
  logic [MBIT-1:0] sgt_res;
  logic [MBIT-1:0] shr_res;
  logic [MBIT-1:0] pop_res;

  // Two's complement wrap falls out of truncation to MBIT bits.
  assign sub_res = arg_a - arg_b;

  assign sgt_res = {{(MBIT-1){1'b0}}, ($signed(arg_a) > $signed(arg_b))};

  // Shift amount widened to 32 bits so the out-of-range test against MBIT
  // is a plain unsigned compare; MBIT never exceeds 32.
  logic [31:0] shamt;
  assign shamt   = 32'(arg_b);
  assign shr_res = (shamt >= 32'(MBIT)) ? '0 : (arg_a >> shamt);

  // Ripple population count: pop_acc[k] holds the count of bits 0..k-1.
  // The maximum count MBIT always fits in MBIT bits for MBIT >= 2.
  logic [MBIT-1:0] pop_acc [0:MBIT];
  assign pop_acc[0] = '0;

  generate
    for (genvar gi = 0; gi < MBIT; gi++) begin : g_pop
      assign pop_acc[gi+1] = pop_acc[gi] + {{(MBIT-1){1'b0}}, arg_a[gi]};
    end
  endgenerate

  assign pop_res = pop_acc[MBIT];

  // -------------------------------------------------------------------------
  // Opcode select and result register.
  // -------------------------------------------------------------------------
  logic [MBIT-1:0] result_d;
  logic [MBIT-1:0] result_q;

  always_comb begin
    result_d = '0;
    case (oper)
      OP_SUB:    result_d = sub_res;
      OP_SGT:    result_d = sgt_res;
      OP_SHR:    result_d = shr_res;
      OP_POPCNT: result_d = pop_res;
      default:   result_d = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rsn) begin
    if (i_rsn) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign bus.o_result = result_q;

endmodule : exe_unit_w47_core

// File: tb/tb_exe_unit_w47_core.sv
// ---------------------------------------------------------------------------
// tb_exe_unit_w47_core
// Directed bench for exe_unit_w47_core at MBIT=4, NBIT=2. Inputs change on
// the falling edge, results are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_exe_unit_w47_core;

  localparam int MBIT = 4;
  localparam int NBIT = 2;

  logic i_clk;
  logic i_rsn;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  exe_unit_w47_core_if #(.MBIT(MBIT), .NBIT(NBIT)) bus ();

  exe_unit_w47_core #(.MBIT(MBIT), .NBIT(NBIT)) dut (
    .i_clk (i_clk),
    .i_rsn (i_rsn),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [MBIT-1:0] obs,
                           input logic [MBIT-1:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      failures_cnt++;
      $display("FAIL %s got=%b expected=%b", tag, obs, exp);
    end else begin
      $display("ok   %s result=%b", tag, obs);
    end
  endtask

  // Drive one operation on the falling edge, check it one edge later.
  task automatic run_op(input string tag, input logic [MBIT-1:0] a,
                        input logic [MBIT-1:0] b, input logic [NBIT-1:0] op,
                        input logic [MBIT-1:0] exp);
    @(negedge i_clk);
    bus.i_argA = a;
    bus.i_argB = b;
    bus.i_oper = op;
    @(posedge i_clk);
    #1;
    check_val(tag, bus.o_result, exp);
  endtask

  initial begin
    i_rsn      = 1'b1;
    bus.i_argA = 4'b0000;
    bus.i_argB = 4'b0000;
    bus.i_oper = 2'd0;
    #1;
    check_val("reset_init", bus.o_result, 4'b0000);
    @(posedge i_clk);
    #1;
    check_val("reset_hold_edge", bus.o_result, 4'b0000);
    @(negedge i_clk);
    i_rsn = 1'b0;

    // SUB
    run_op("sub_f_2",   4'b1111, 4'b0010, 2'd0, 4'b1101);
    run_op("sub_f_0",   4'b1111, 4'b0000, 2'd0, 4'b1111);
    run_op("sub_f_8",   4'b1111, 4'b1000, 2'd0, 4'b0111);
    run_op("sub_f_a",   4'b1111, 4'b1010, 2'd0, 4'b0101);
    run_op("sub_wrap",  4'b1000, 4'b0001, 2'd0, 4'b0111);

    // SGT
    run_op("sgt_c_a",   4'b1100, 4'b1010, 2'd1, 4'b0001);
    run_op("sgt_8_a",   4'b1000, 4'b1010, 2'd1, 4'b0000);
    run_op("sgt_0_2",   4'b0000, 4'b0010, 2'd1, 4'b0000);
    run_op("sgt_4_2",   4'b0100, 4'b0010, 2'd1, 4'b0001);
    run_op("sgt_1_a",   4'b0001, 4'b1010, 2'd1, 4'b0001);
    run_op("sgt_a_1",   4'b1010, 4'b0001, 2'd1, 4'b0000);
    run_op("sgt_eq",    4'b0110, 4'b0110, 2'd1, 4'b0000);

    // SHR
    run_op("shr_by8",   4'b1111, 4'b1000, 2'd2, 4'b0000);
    run_op("shr_by0",   4'b1111, 4'b0000, 2'd2, 4'b1111);
    run_op("shr_by1",   4'b1111, 4'b0001, 2'd2, 4'b0111);
    run_op("shr_by2",   4'b1111, 4'b0010, 2'd2, 4'b0011);
    run_op("shr_by3",   4'b1111, 4'b0011, 2'd2, 4'b0001);
    run_op("shr_by4",   4'b1111, 4'b0100, 2'd2, 4'b0000);
    run_op("shr_a_by1", 4'b1010, 4'b0001, 2'd2, 4'b0101);

    // POPCNT with B held at 0100
    run_op("pop_2",     4'b0010, 4'b0100, 2'd3, 4'b0001);
    run_op("pop_0",     4'b0000, 4'b0100, 2'd3, 4'b0000);
    run_op("pop_8",     4'b1000, 4'b0100, 2'd3, 4'b0001);
    run_op("pop_a",     4'b1010, 4'b0100, 2'd3, 4'b0010);
    run_op("pop_f",     4'b1111, 4'b0100, 2'd3, 4'b0100);

    // Asynchronous reset mid-cycle while a nonzero result is held
    run_op("pre_rst",   4'b1111, 4'b0000, 2'd0, 4'b1111);
    #2;
    i_rsn = 1'b1;
    #1;
    check_val("rst_async", bus.o_result, 4'b0000);
    @(posedge i_clk);
    #1;
    check_val("rst_hold1", bus.o_result, 4'b0000);
    @(posedge i_clk);
    #1;
    check_val("rst_hold2", bus.o_result, 4'b0000);
    @(negedge i_clk);
    bus.i_argA = 4'b1111;
    bus.i_argB = 4'b0010;
    bus.i_oper = 2'd0;
    i_rsn      = 1'b0;
    @(posedge i_clk);
    #1;
    check_val("rst_release", bus.o_result, 4'b1101);

    // Back-to-back opcode switching
    run_op("b2b_sub",   4'b0101, 4'b0011, 2'd0, 4'b0010);
    run_op("b2b_sgt",   4'b0011, 4'b1110, 2'd1, 4'b0001);
    run_op("b2b_shr",   4'b1100, 4'b0001, 2'd2, 4'b0110);
    run_op("b2b_pop",   4'b0111, 4'b1111, 2'd3, 4'b0011);
    run_op("b2b_sub2",  4'b0000, 4'b0001, 2'd0, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule : tb_exe_unit_w47_core

// File: doc/exe_unit_w47_core.md
Name: exe_unit_w47_core

Overview:
Small parameterised execution unit (ALU slice) for the w47 datapath. It takes two MBIT-wide operands and an NBIT-wide opcode, and computes one of four operations. The result is registered, so it appears on o_result one clock after the operands are sampled. It sits between operand/opcode decode and the result bus, and is instantiated as a single unit.

Parameters:
MBIT, 4, operand and result width in bits; legal range 2..32.
NBIT, 2, opcode width in bits; legal range 2..8; only encodings 0..3 are defined.

Ports:
i_clk  input  1  clock; all state changes on the rising edge.
i_rsn  input  1  reset; asynchronous and active-high.
i_argA  input  MBIT  operand A; two's complement where signed.
i_argB  input  MBIT  operand B; two's complement where signed; unsigned shift amount for op 2.
i_oper  input  NBIT  opcode.
o_result  output  MBIT  registered result.

Behaviour:
- Reset: asynchronous and active-high. While i_rsn=1, o_result=0 immediately, independent of the clock, and holds 0. Release is synchronised to the next rising edge. The first result after release is the one computed at that edge.
- Latency: exactly 1 cycle. On each rising edge with reset low, o_result <= f(i_argA, i_argB, i_oper).
- No handshake. A new operation is accepted every cycle. Inputs are sampled only at the rising edge.
- Combinational next-result function:
  - op 0 (SUB): A - B, modulo 2^MBIT, two's complement wrap. No overflow flag; overflowing results simply wrap.
  - op 1 (SGT): signed compare. Result is 1 (zero-extended to MBIT) if signed(A) > signed(B), else 0. Equal operands give 0.
  - op 2 (SHR): logical right shift of A by unsigned(B), zero fill. If unsigned(B) >= MBIT, result is 0.
  - op 3 (POPCNT): number of 1 bits in A, as an unsigned value zero-extended to MBIT. A is all-ones gives MBIT. B is ignored.
  - Encodings >= 4 (only possible when NBIT>2): result 0.
- X-free: every opcode value produces a defined result. No latches; a single output register bank.
- Boundary conditions:
  - SUB of most-negative minus positive wraps (e.g. 1000-0001=0111 for MBIT=4).
  - SHR by 0 returns A unchanged.
  - POPCNT of 0 is 0.
- An opcode change takes effect on the next edge, with no pipeline hazards (single stage).

Test Plan:
- SUB, MBIT=4: A=1111 with B=0010 -> 1101; B=0000 -> 1111; B=1000 -> 0111; B=1010 -> 0101. Each value appears one edge after the inputs are applied.
- SGT: A=1100,B=1010 -> 0001; A=1000,B=1010 -> 0000; A=0000,B=0010 -> 0000; A=0100,B=0010 -> 0001; A=0001,B=1010 -> 0001; A=1010,B=0001 -> 0000; A=B -> 0000.
- SHR: A=1111 with B=1000 -> 0000; B=0000 -> 1111; B=0001 -> 0111; B=0010 -> 0011; B=0011 -> 0001; B=0100 -> 0000.
- POPCNT, B held at 0100: A=0010 -> 0001; A=0000 -> 0000; A=1000 -> 0001; A=1010 -> 0010; A=1111 -> 0100.
- Reset:
  - Assert i_rsn mid-stream between clock edges: o_result goes to 0000 without waiting for a clock edge, and stays 0000 across edges while asserted.
  - After deassertion, the first rising edge loads the current operation's result.
- Back-to-back opcode switching every cycle (0,1,2,3 in sequence): each result matches its own cycle's inputs, with no carry-over from the previous operation.
